// File: rtl/rr_burst_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the shared consumer.
// master = requester/consumer side, slave = arbiter side.
interface rr_burst_arbiter_if #(
    parameter int N      = 5,
    parameter int DATA_W = 16
);
    logic [N-1:0]        request;
    logic [N*DATA_W-1:0] data_in;
    logic                out_ready;
    logic [N-1:0]        grant;
    logic [DATA_W-1:0]   data_out;
    logic                out_valid;
    logic [N-1:0]        ack;
    logic                last;
    logic                busy;

    modport master (
        output request, data_in, out_ready,
        input  grant, data_out, out_valid, ack, last, busy
    );

    modport slave (
        input  request, data_in, out_ready,
        output grant, data_out, out_valid, ack, last, busy
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of up to MAX_BURST
// beats on a shared valid/ready channel, with one idle bubble between grants.
module rr_burst_arbiter #(
    parameter int N         = 5,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    rr_burst_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   beat_q, beat_d;

    logic [N-1:0][DATA_W-1:0] din;
    logic                     win_found;
    logic [IDX_W-1:0]         win_idx;
    logic [IDX_W-1:0]         scan_idx;
    logic                     owner_req;
    logic                     xfer;
    logic                     final_beat;

    assign din        = bus.data_in;
    assign owner_req  = bus.request[owner_q];
    assign xfer       = (state_q == GRANT) && owner_req && bus.out_ready;
    assign final_beat = (beat_q == CNT_W'(MAX_BURST - 1));

    // First set request bit scanning upward from ptr_q, wrapping mod N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = IDX_W'((int'(ptr_q) + i) % N);
            if (!win_found && bus.request[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = GRANT;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    beat_d           = '0;
                end
            end
            GRANT: begin
                // A dropped request releases without a transfer, even if out_ready is high.
                if (!owner_req || (xfer && final_beat)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    beat_d  = '0;
                    ptr_d   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + 1'b1;
                end else if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.grant     = grant_q;
        bus.busy      = (state_q == GRANT);
        bus.out_valid = (state_q == GRANT) && owner_req;
        bus.data_out  = (state_q == GRANT) ? din[owner_q] : '0;
        bus.ack       = grant_q & {N{xfer}};
        bus.last      = bus.out_valid && final_beat;
    end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Cycle-by-cycle vector table for rr_burst_arbiter; expected outputs are queued as each
// row is driven and compared on the following falling edge.
module tb_rr_burst_arbiter;
    localparam int N         = 5;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [N-1:0]      grant;
        logic              out_valid;
        logic [N-1:0]      ack;
        logic              last;
        logic              busy;
        logic [DATA_W-1:0] data;
    } obs_t;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         rdy;
        obs_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];
    vec_t vecs[$];

    rr_burst_arbiter_if #(.N(N), .DATA_W(DATA_W)) bus ();

    rr_burst_arbiter #(.N(N), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] slice_of(logic [N-1:0] g);
        for (int i = 0; i < N; i++)
            if (g[i]) return 16'h000A + 16'(i);
        return '0;
    endfunction

    function automatic vec_t mk(logic r, logic [N-1:0] q, logic y,
                                logic [N-1:0] g, logic v, logic [N-1:0] a, logic l, logic b);
        vec_t t;
        t.rst           = r;
        t.req           = q;
        t.rdy           = y;
        t.exp.grant     = g;
        t.exp.out_valid = v;
        t.exp.ack       = a;
        t.exp.last      = l;
        t.exp.busy      = b;
        t.exp.data      = slice_of(g);
        return t;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.grant     = bus.grant;
        o.out_valid = bus.out_valid;
        o.ack       = bus.ack;
        o.last      = bus.last;
        o.busy      = bus.busy;
        o.data      = bus.data_out;
        return o;
    endfunction

    task automatic check(string name, obs_t got, obs_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got grant=%b vld=%b ack=%b last=%b busy=%b data=%h, want grant=%b vld=%b ack=%b last=%b busy=%b data=%h",
                     name, got.grant, got.out_valid, got.ack, got.last, got.busy, got.data,
                     want.grant, want.out_valid, want.ack, want.last, want.busy, want.data);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Drive one cycle's inputs, queue its expected outputs, compare mid-cycle, step to next edge.
    task automatic apply(string name, logic r, logic [N-1:0] q, logic y, obs_t want);
        reset         = r;
        bus.request   = q;
        bus.out_ready = y;
        exp_q.push_back(want);
        @(negedge clk);
        check(name, sample(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        obs_t hold;
        int   nack;
        int   cyc;

        bus.data_in   = {16'h000E, 16'h000D, 16'h000C, 16'h000B, 16'h000A};
        reset         = 1'b1;
        bus.request   = '0;
        bus.out_ready = 1'b1;

        // rst, request, out_ready | grant, out_valid, ack, last, busy
        // 1: reset then idle
        vecs.push_back(mk(1, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(1, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        // 2: single requester 2, full burst, bubble, regrant
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(1, 5'b00000, 1, 5'b00100, 0, 5'b00000, 0, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        // 3: requesters 2 and 3 alternate
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00100, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b01000, 1, 5'b01000, 0, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b01000, 1, 5'b01000, 0, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b01000, 1, 5'b01000, 0, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b01000, 1, 5'b01000, 1, 1));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b01100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(1, 5'b00000, 1, 5'b00100, 0, 5'b00000, 0, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        // 4: back-pressure 1,0,0,1,1,1
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 0, 5'b00100, 1, 5'b00000, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 0, 5'b00100, 1, 5'b00000, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 0, 1));
        vecs.push_back(mk(0, 5'b00100, 1, 5'b00100, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        // 5: requester 4 drops after 2 beats, pointer wraps to 0
        vecs.push_back(mk(0, 5'b10000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b10000, 1, 5'b10000, 1, 5'b10000, 0, 1));
        vecs.push_back(mk(0, 5'b10000, 1, 5'b10000, 1, 5'b10000, 0, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 5'b10000, 0, 5'b00000, 0, 1));
        vecs.push_back(mk(0, 5'b10001, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b10001, 1, 5'b00001, 1, 5'b00001, 0, 1));
        vecs.push_back(mk(1, 5'b00000, 1, 5'b00001, 0, 5'b00000, 0, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0));
        // 6: reset mid-burst of requester 1, then 1 wins again from ptr 0
        vecs.push_back(mk(0, 5'b00010, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00010, 1, 5'b00010, 1, 5'b00010, 0, 1));
        vecs.push_back(mk(0, 5'b00010, 1, 5'b00010, 1, 5'b00010, 0, 1));
        vecs.push_back(mk(1, 5'b00010, 0, 5'b00010, 1, 5'b00000, 0, 1));
        vecs.push_back(mk(0, 5'b00110, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00110, 1, 5'b00010, 1, 5'b00010, 0, 1));
        // non-owner request churn does not disturb the grant; fairness skips past 1
        vecs.push_back(mk(0, 5'b00111, 1, 5'b00010, 1, 5'b00010, 0, 1));
        vecs.push_back(mk(0, 5'b00011, 1, 5'b00010, 1, 5'b00010, 0, 1));
        vecs.push_back(mk(0, 5'b00010, 1, 5'b00010, 1, 5'b00010, 1, 1));
        vecs.push_back(mk(0, 5'b00011, 1, 5'b00000, 0, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00011, 1, 5'b00001, 1, 5'b00001, 0, 1));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].rdy, vecs[i].exp);

        // Requester 0 owns with one beat done: long stall keeps grant and count frozen.
        hold = '{grant: 5'b00001, out_valid: 1'b1, ack: 5'b00000, last: 1'b0, busy: 1'b1, data: 16'h000A};
        for (int i = 0; i < 6; i++)
            apply($sformatf("stall%0d", i), 1'b0, 5'b00001, 1'b0, hold);

        // Release must follow exactly the three remaining beats.
        bus.out_ready = 1'b1;
        nack = 0;
        cyc  = 0;
        while (cyc < 10) begin
            @(negedge clk);
            if (bus.ack[0]) nack++;
            if (bus.grant == '0) break;
            cyc++;
        end
        check_int("stall_timeout", (cyc < 10) ? 1 : 0, 1);
        check_int("stall_remaining_acks", nack, MAX_BURST - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
